// File: rtl/rns4_reverse_converter.sv
// rns4_reverse_converter: sequential mixed-radix reverse converter for the residue set
// {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}; one digit per state, registered result behind valid/ready.
module rns4_reverse_converter #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       r1,
    input  logic [N-1:0]       r2,
    input  logic [N:0]         r3,
    input  logic [N:0]         r4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*N:0]       out_x,
    output logic               out_err
);
    localparam int OUT_W = 4*N+1;
    localparam int W = 2*N+4;

    if (N < 3 || N > 16) begin : g_bad_n
        $error("rns4_reverse_converter: N must be in 3..16");
    end

    function automatic longint mod_inv(input longint a, input longint m);
        longint t = 0, nt = 1, r = m, nr = a % m, qq, tmp;
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt;
            t = nt;
            nt = tmp;
            tmp = r - qq * nr;
            r = nr;
            nr = tmp;
        end
        return (t < 0) ? t + m : t;
    endfunction

    localparam logic [W-1:0] M1 = W'((1 << N) - 1);
    localparam logic [W-1:0] M3 = W'((1 << N) + 1);
    localparam logic [W-1:0] M4 = W'((1 << (N+1)) - 1);
    localparam logic [W-1:0] I23 = W'(mod_inv(1 << N, (1 << N) + 1));
    localparam logic [W-1:0] I13 = W'(mod_inv((1 << N) - 1, (1 << N) + 1));
    localparam logic [W-1:0] I24 = W'(mod_inv(1 << N, (1 << (N+1)) - 1));
    localparam logic [W-1:0] I14 = W'(mod_inv((1 << N) - 1, (1 << (N+1)) - 1));
    localparam logic [W-1:0] I34 = W'(mod_inv((1 << N) + 1, (1 << (N+1)) - 1));
    localparam logic [OUT_W-1:0] P1 = OUT_W'((1 << N) - 1);
    localparam logic [OUT_W-1:0] P3 = OUT_W'((1 << N) + 1);

    // End-around-carry reduction mod 2^k-1; four folds cover any W-bit input.
    function automatic logic [W-1:0] fold(input logic [W-1:0] v, input int k);
        logic [W-1:0] msk, y;
        msk = (W'(1) << k) - W'(1);
        y = v;
        for (int i = 0; i < 4; i++) y = (y & msk) + (y >> k);
        return (y == msk) ? '0 : y;
    endfunction

    // Reduction mod 2^N+1 for v < 2^(2N+2): 2^N == -1, 2^(2N) == 1.
    function automatic logic [W-1:0] red3(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = W'(v[N-1:0]) + (v >> (2*N)) + M3 - W'(v[2*N-1:N]);
        s = (s >= M3) ? s - M3 : s;
        return (s >= M3) ? s - M3 : s;
    endfunction

    typedef enum logic [2:0] {IDLE, D2, D3, D4, ACC, DONE} state_t;
    state_t st, nxt;

    logic [N-1:0] q1, d1, d2;
    logic [N:0] q3, q4, d3, d4;
    logic err_q;
    logic [OUT_W-1:0] x_q, xo;
    logic [W-1:0] e1, e2, e3, n2, n3, n4, t3, t4;

    assign in_ready = (st == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else st <= nxt;
    end

    always_comb begin
        nxt = (st == IDLE) ? (in_valid ? D2 : IDLE) :
              (st == DONE) ? ((out_valid && out_ready) ? IDLE : DONE) :
              state_t'(st + 3'd1);
    end

    always_comb begin
        e1 = W'(d1);
        e2 = W'(d2);
        e3 = W'(d3);
        n2 = fold(W'(q1) + M1 - e1, N);
        t3 = red3(W'(q3) + M3 - e1);
        t3 = red3(t3 * I23);
        t3 = red3(t3 + M3 - e2);
        n3 = red3(t3 * I13);
        t4 = fold(W'(q4) + M4 - e1, N+1);
        t4 = fold(t4 * I24, N+1);
        t4 = fold(t4 + M4 - e2, N+1);
        t4 = fold(t4 * I14, N+1);
        t4 = fold(t4 + M4 - e3, N+1);
        n4 = fold(t4 * I34, N+1);
        xo = OUT_W'(d1) + ((OUT_W'(d2) + P1 * (OUT_W'(d3) + P3 * OUT_W'(d4))) << N);
    end

    // The result is registered in ACC and published one cycle later, so the
    // wide multiply-add never sits directly in front of out_x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q3 <= '0;
            q4 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            d4 <= '0;
            err_q <= 1'b0;
            x_q <= '0;
            out_valid <= 1'b0;
            out_x <= '0;
            out_err <= 1'b0;
        end else begin
            if (st == IDLE && in_valid) begin
                q1 <= r1;
                q3 <= r3;
                q4 <= r4;
                d1 <= r2;
                err_q <= (&r1) | (&r4) | (r3 > {1'b1, {N{1'b0}}});
            end
            if (st == D2) d2 <= N'(n2);
            if (st == D3) d3 <= (N+1)'(n3);
            if (st == D4) d4 <= (N+1)'(n4);
            if (st == ACC) x_q <= xo;
            if (st == DONE) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_x <= err_q ? '0 : x_q;
                    out_err <= err_q;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rns4_reverse_converter.sv
// tb_rns4_reverse_converter: scoreboard bench for the N=8 converter; expectations are
// pushed when a tuple is accepted and popped when a result appears.
module tb_rns4_reverse_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [7:0] r1 = '0, r2 = '0;
    logic [8:0] r3 = '0, r4 = '0;
    logic in_ready, out_valid, out_err;
    logic [32:0] out_x;

    typedef struct {
        logic [32:0] x;
        logic        e;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    localparam longint unsigned M = 64'd8573026560;

    rns4_reverse_converter #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [8:0] c,
                       input logic [8:0] d, input logic [32:0] x, input logic e);
        r1 = a;
        r2 = b;
        r3 = c;
        r4 = d;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        sb.push_back('{x: x, e: e});
        #1;
        in_valid = 1'b0;
        r1 = ~a;
        r2 = ~b;
        r3 = ~c;
        r4 = ~d;
        check("busy_after_accept", in_ready, 0);
    endtask

    task automatic get(input string tag);
        int lat = 0;
        exp_t ex;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        ex = sb.pop_front();
        check({tag, "_x"}, out_x, ex.x);
        check({tag, "_err"}, out_err, ex.e);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_consumed"}, out_valid, 0);
        end
    endtask

    task automatic put_x(input longint unsigned x);
        put(8'(x % 255), 8'(x % 256), 9'(x % 257), 9'(x % 511), 33'(x), 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        put(0, 0, 0, 0, 0, 0);
        get("zero");
        put(235, 232, 229, 489, 1000, 0);
        get("x1000");
        put(69, 21, 157, 211, 123456789, 0);
        get("x123456789");
        put(254, 255, 256, 510, 33'd8573026559, 0);
        get("xmax");
        put(255, 0, 0, 0, 0, 1);
        get("err_r1");
        put(0, 0, 0, 511, 0, 1);
        get("err_r4");
        put(0, 0, 257, 0, 0, 1);
        get("err_r3");
        put(0, 255, 256, 0, 33'd8573026559 - 33'd0, 1'b0 | 1'b0);
        sb[sb.size()-1].x = 33'((64'd255 * 257 * 511 * 256 + 64'd255) % M);
        // (0,255,256,0): X = 255 + 256*k; solved by search below instead of hand
        begin
            longint unsigned xs = 0;
            for (longint unsigned k = 0; k < 255 * 257 * 511; k++) begin
                xs = 255 + 256 * k;
                if (xs % 255 == 0 && xs % 257 == 256 && xs % 511 == 0) break;
            end
            sb[sb.size()-1].x = 33'(xs);
        end
        get("r2r3_edge");

        for (int i = 0; i < 8; i++) begin
            longint unsigned x;
            x = {$urandom, $urandom} % M;
            put_x(x);
            get("random");
        end

        out_ready = 1'b0;
        put(235, 232, 229, 489, 1000, 0);
        get("bp");
        r1 = 69;
        r2 = 21;
        r3 = 157;
        r4 = 211;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_hold_x", out_x, 1000);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        put(69, 21, 157, 211, 123456789, 0);
        get("bp_next");

        put(235, 232, 229, 489, 1000, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_valid", out_valid, 0);
        check("midrst_x", out_x, 0);
        check("midrst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", out_valid, 0);
        end
        put(235, 232, 229, 489, 1000, 0);
        get("after_rst");

        out_ready = 1'b0;
        put(69, 21, 157, 211, 123456789, 0);
        get("done_rst");
        rst_n = 1'b0;
        #1;
        check("donerst_valid", out_valid, 0);
        check("donerst_x", out_x, 0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
